// File: rtl/dsync_tx.sv
// dsync_tx -- framed serial NRZ transmitter clocked from CLOCK_10.
//
// Frame on dat_out: PREAMBLE_BITS alternating bits (0,1,...,1), start bit 0,
// eight data bits LSB first, optional even-parity bit, stop bit 1.
// Every bit is held for BIT_PERIOD clocks; En_out strobes on the first clock
// of each bit. The line idles high.
//
// Optional feature: define DSYNC_TX_PARITY_EN to insert the even-parity bit
// (XOR of the eight data bits) between the last data bit and the stop bit.
//
// Handshake: a byte is transferred on a rising edge where tx_valid and
// tx_ready are both high. tx_ready is high only while the FSM sits in IDLE,
// so tx_data/tx_valid are ignored for the whole frame, and the captured byte
// lives in an internal shift register that nothing outside can touch.
//
// All outputs except busy and dbg_state_o are registered. They are computed
// from the next-state values, so the first preamble bit and its En_out strobe
// appear in the cycle right after the handshake edge.

module dsync_tx #(
   parameter int BIT_PERIOD    = 1000,  // clocks per bit, 4..1023
   parameter int PREAMBLE_BITS = 8      // even, 2..14
) (
   input  logic       CLOCK_10,
   input  logic       reset_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       dat_out,
   output logic       En_out,
   output logic       busy,
   output logic [2:0] dbg_state_o     // current FSM state, for observation
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_PREAMBLE = 3'd1,
      S_START    = 3'd2,
      S_DATA     = 3'd3,
`ifdef DSYNC_TX_PARITY_EN
      S_PARITY   = 3'd4,
`endif
      S_STOP     = 3'd5
   } state_t;

   // Last value of the in-bit cycle counter and of the preamble bit index.
   localparam logic [9:0] BIT_LAST = 10'(BIT_PERIOD - 1);
   localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_BITS - 1);

   state_t     state_q,   state_d;
   logic [9:0] bit_cnt_q, bit_cnt_d;   // cycle within the current bit
   logic [3:0] pre_cnt_q, pre_cnt_d;   // preamble bit index
   logic [2:0] dat_idx_q, dat_idx_d;   // data bit index, wraps 7 -> 0
   logic [7:0] shift_q,   shift_d;     // captured byte, shifted right per bit
`ifdef DSYNC_TX_PARITY_EN
   logic       parity_q,  parity_d;    // even parity of the captured byte
`endif
   logic       dat_q,     dat_d;
   logic       en_q,      en_d;
   logic       rdy_q,     rdy_d;
   logic       bit_last;
   logic       handshake;

   assign bit_last  = (bit_cnt_q == BIT_LAST);
   assign handshake = tx_valid & rdy_q;

   // Next-state and datapath: capture on handshake, then walk the frame one bit at a time.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      pre_cnt_d = pre_cnt_q;
      dat_idx_d = dat_idx_q;
      shift_d   = shift_q;
`ifdef DSYNC_TX_PARITY_EN
      parity_d  = parity_q;
`endif
      if (state_q == S_IDLE) begin
         if (handshake) begin
            state_d   = S_PREAMBLE;
            bit_cnt_d = 10'd0;
            pre_cnt_d = 4'd0;
            dat_idx_d = 3'd0;
            shift_d   = tx_data;
`ifdef DSYNC_TX_PARITY_EN
            parity_d  = ^tx_data;
`endif
         end
      end else begin
         // The cycle counter runs 0..BIT_PERIOD-1 in every non-idle state.
         bit_cnt_d = bit_last ? 10'd0 : bit_cnt_q + 10'd1;
         if (bit_last) begin
            unique case (state_q)
               S_PREAMBLE: begin
                  if (pre_cnt_q == PRE_LAST) begin
                     state_d   = S_START;
                     pre_cnt_d = 4'd0;
                  end else begin
                     pre_cnt_d = pre_cnt_q + 4'd1;
                  end
               end
               S_START: begin
                  state_d   = S_DATA;
                  dat_idx_d = 3'd0;
               end
               S_DATA: begin
                  shift_d   = {1'b0, shift_q[7:1]};
                  dat_idx_d = dat_idx_q + 3'd1;
                  if (dat_idx_q == 3'd7) begin
`ifdef DSYNC_TX_PARITY_EN
                     state_d = S_PARITY;
`else
                     state_d = S_STOP;
`endif
                  end
               end
`ifdef DSYNC_TX_PARITY_EN
               S_PARITY: begin
                  state_d = S_STOP;
               end
`endif
               S_STOP: begin
                  state_d = S_IDLE;
               end
               default: begin
                  state_d = S_IDLE;
               end
            endcase
         end
      end
   end

   // Output decode from next-state values so the registered outputs line up with the bit.
   always_comb begin
      dat_d = 1'b1;
      en_d  = 1'b0;
      rdy_d = 1'b0;
      unique case (state_d)
         S_IDLE:     dat_d = 1'b1;
         S_PREAMBLE: dat_d = pre_cnt_d[0];
         S_START:    dat_d = 1'b0;
         S_DATA:     dat_d = shift_d[0];
`ifdef DSYNC_TX_PARITY_EN
         S_PARITY:   dat_d = parity_d;
`endif
         S_STOP:     dat_d = 1'b1;
         default:    dat_d = 1'b1;
      endcase
      // A zero counter outside IDLE is always the first cycle of a bit.
      en_d  = (state_d != S_IDLE) && (bit_cnt_d == 10'd0);
      rdy_d = (state_d == S_IDLE);
   end

   // FSM state, counters and captured byte; reset aborts any frame in flight.
   always_ff @(posedge CLOCK_10 or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         bit_cnt_q <= 10'd0;
         pre_cnt_q <= 4'd0;
         dat_idx_q <= 3'd0;
         shift_q   <= 8'd0;
`ifdef DSYNC_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         pre_cnt_q <= pre_cnt_d;
         dat_idx_q <= dat_idx_d;
         shift_q   <= shift_d;
`ifdef DSYNC_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   // Registered line, strobe and ready; line high, strobe and ready low in reset.
   always_ff @(posedge CLOCK_10 or negedge reset_n) begin
      if (!reset_n) begin
         dat_q <= 1'b1;
         en_q  <= 1'b0;
         rdy_q <= 1'b0;
      end else begin
         dat_q <= dat_d;
         en_q  <= en_d;
         rdy_q <= rdy_d;
      end
   end

   assign dat_out     = dat_q;
   assign En_out      = en_q;
   assign tx_ready    = rdy_q;
   assign busy        = (state_q != S_IDLE);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dsync_tx.sv
// tb_dsync_tx -- bench for dsync_tx.
// Two instances share one clock: u_fast (BIT_PERIOD=10) carries the directed
// and random byte traffic plus the mid-frame reset; u_slow (default
// BIT_PERIOD=1000) sends three back-to-back frames. Expected line bits are
// built from the frame rules when a byte is handed over and queued; a monitor
// pops one expected bit per En_out strobe and checks value, bit length,
// line hold and pulse count per frame.
`timescale 1ns/1ps

module tb_dsync_tx;

  localparam int PB  = 8;
  localparam int BP0 = 10;
  localparam int BP1 = 1000;
`ifdef DSYNC_TX_PARITY_EN
  localparam int FB = PB + 11;
`else
  localparam int FB = PB + 10;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_n      [2];
  logic [7:0] tx_data_s  [2];
  logic       tx_valid_s [2];
  logic       tx_ready_s [2];
  logic       dat_s      [2];
  logic       en_s       [2];
  logic       busy_s     [2];
  logic [2:0] dbg_s      [2];

  int checks = 0;
  int errors = 0;

  logic exp_q0[$];
  logic exp_q1[$];
  int   last_low[2];

  dsync_tx #(.BIT_PERIOD(BP0), .PREAMBLE_BITS(PB)) u_fast (
    .CLOCK_10(clk), .reset_n(rst_n[0]), .tx_data(tx_data_s[0]), .tx_valid(tx_valid_s[0]),
    .tx_ready(tx_ready_s[0]), .dat_out(dat_s[0]), .En_out(en_s[0]), .busy(busy_s[0]),
    .dbg_state_o(dbg_s[0])
  );

  dsync_tx #(.PREAMBLE_BITS(PB)) u_slow (
    .CLOCK_10(clk), .reset_n(rst_n[1]), .tx_data(tx_data_s[1]), .tx_valid(tx_valid_s[1]),
    .tx_ready(tx_ready_s[1]), .dat_out(dat_s[1]), .En_out(en_s[1]), .busy(busy_s[1]),
    .dbg_state_o(dbg_s[1])
  );

  function automatic int bp_of(input int i);
    return (i == 0) ? BP0 : BP1;
  endfunction

  task automatic check(input int i, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL inst%0d %s: got %0h expected %0h (t=%0t)", i, name, act, exp, $time);
    end
  endtask

  // reference model: frame bits from the frame rules
  task automatic push_bit(input int i, input logic v);
    if (i == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endtask

  task automatic push_frame(input int i, input logic [7:0] b);
    for (int k = 0; k < PB; k++) push_bit(i, (k % 2) == 1);
    push_bit(i, 1'b0);
    for (int k = 0; k < 8; k++) push_bit(i, b[k]);
`ifdef DSYNC_TX_PARITY_EN
    push_bit(i, ^b);
`endif
    push_bit(i, 1'b1);
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic pop_exp(input int i);
    if (i == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  // driver: call at a negedge; returns #1 after the handshake edge
  task automatic send(input int i, input logic [7:0] b, input bit keep, output int hs);
    int lim;
    int t;
    lim = 3 * FB * bp_of(i) + 20;
    t   = 0;
    hs  = -1;
    tx_data_s[i]  = b;
    tx_valid_s[i] = 1'b1;
    while (tx_ready_s[i] !== 1'b1 && t < lim) begin
      @(negedge clk);
      t++;
    end
    if (t >= lim) begin
      checks++;
      errors++;
      $display("FAIL inst%0d send_timeout: tx_ready never seen within %0d cycles", i, lim);
    end else begin
      push_frame(i, b);
      hs = cyc;
    end
    @(posedge clk);
    #1;
    if (!keep) tx_valid_s[i] = 1'b0;
  endtask

  // scoreboard monitor
  int   run    [2];
  bit   in_fr  [2];
  logic cur    [2];
  int   pulses [2];
  int   low_run[2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n[i]) begin
        in_fr[i]   = 1'b0;
        run[i]     = 0;
        pulses[i]  = 0;
        low_run[i] = 0;
        if (i == 0) exp_q0.delete();
        else        exp_q1.delete();
      end else begin
        if (tx_ready_s[i] !== 1'b1) low_run[i]++;
        else begin
          if (low_run[i] != 0) last_low[i] = low_run[i];
          low_run[i] = 0;
        end
        if (en_s[i] === 1'b1) begin
          if (in_fr[i]) check(i, "bit_len", run[i], bp_of(i));
          check(i, "busy_at_en", busy_s[i], 1);
          if (qsize(i) == 0) begin
            checks++;
            errors++;
            $display("FAIL inst%0d unexpected_en: got strobe expected none (t=%0t)", i, $time);
          end else begin
            check(i, "bit_val", dat_s[i], pop_exp(i));
          end
          cur[i]    = dat_s[i];
          run[i]    = 1;
          in_fr[i]  = 1'b1;
          pulses[i] = pulses[i] + 1;
        end else if (in_fr[i]) begin
          if (busy_s[i] === 1'b1) begin
            check(i, "bit_hold", dat_s[i], cur[i]);
            run[i]++;
          end else begin
            check(i, "last_bit_len", run[i], bp_of(i));
            check(i, "pulses_per_frame", pulses[i], FB);
            check(i, "idle_line_after", dat_s[i], 1);
            in_fr[i]  = 1'b0;
            pulses[i] = 0;
          end
        end else if (busy_s[i] === 1'b1) begin
          checks++;
          errors++;
          $display("FAIL inst%0d busy_no_en: got busy 1 expected strobe first (t=%0t)", i, $time);
        end
      end
    end
  end

  // stimulus
  int h0, h1, h2;
  int hf0, hf1, hfx;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_n[i]      = 1'b1;
      tx_data_s[i]  = 8'h00;
      tx_valid_s[i] = 1'b0;
    end
    #1;
    rst_n[0] = 1'b0;
    rst_n[1] = 1'b0;
    #20;
    for (int i = 0; i < 2; i++) begin
      check(i, "rst_dat", dat_s[i], 1);
      check(i, "rst_busy", busy_s[i], 0);
      check(i, "rst_en", en_s[i], 0);
      check(i, "rst_ready", tx_ready_s[i], 0);
    end
    @(negedge clk);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(posedge clk);
    #1;
    check(0, "ready_after_rst", tx_ready_s[0], 1);
    check(1, "ready_after_rst", tx_ready_s[1], 1);

    fork
      begin : fast_thread
        @(negedge clk);
        send(0, 8'hA5, 1'b0, hfx);
        // random bytes with random idle gaps
        for (int n = 0; n < 5; n++) begin
          repeat ($urandom_range(0, 25)) @(negedge clk);
          @(negedge clk);
          send(0, 8'($urandom_range(0, 255)), 1'b0, hfx);
        end
        // back-to-back with tx_valid held high
        @(negedge clk);
        send(0, 8'h00, 1'b1, hf0);
        tx_data_s[0] = 8'hFF;
        @(negedge clk);
        send(0, 8'hFF, 1'b0, hf1);
        check(0, "b2b_gap", hf1 - hf0, FB * BP0 + 1);
        check(0, "ready_low_len", last_low[0], FB * BP0);
        // parity patterns
        @(negedge clk);
        send(0, 8'h07, 1'b0, hfx);
        @(negedge clk);
        send(0, 8'h03, 1'b0, hfx);
        // tx_data and tx_valid wiggled mid-frame
        @(negedge clk);
        send(0, 8'h3C, 1'b0, hfx);
        repeat (30) @(negedge clk);
        tx_data_s[0]  = 8'hFF;
        tx_valid_s[0] = 1'b1;
        repeat (3) @(negedge clk);
        tx_valid_s[0] = 1'b0;
        tx_data_s[0]  = 8'($urandom_range(0, 255));
        // reset mid-frame
        @(negedge clk);
        send(0, 8'($urandom_range(0, 255)), 1'b0, hfx);
        repeat (53) @(posedge clk);
        #2;
        rst_n[0] = 1'b0;
        #1;
        check(0, "async_rst_dat", dat_s[0], 1);
        check(0, "async_rst_busy", busy_s[0], 0);
        check(0, "async_rst_en", en_s[0], 0);
        check(0, "async_rst_ready", tx_ready_s[0], 0);
        repeat (3) @(negedge clk);
        rst_n[0] = 1'b1;
        @(posedge clk);
        #1;
        check(0, "ready_after_abort", tx_ready_s[0], 1);
        check(0, "busy_after_abort", busy_s[0], 0);
        repeat (3 * BP0) @(negedge clk);
        send(0, 8'h5A, 1'b0, hfx);
      end
      begin : slow_thread
        @(negedge clk);
        send(1, 8'($urandom_range(0, 255)), 1'b1, h0);
        tx_data_s[1] = 8'($urandom_range(0, 255));
        @(negedge clk);
        send(1, tx_data_s[1], 1'b1, h1);
        tx_data_s[1] = 8'($urandom_range(0, 255));
        @(negedge clk);
        send(1, tx_data_s[1], 1'b0, h2);
        check(1, "slow_gap1", h1 - h0, FB * BP1 + 1);
        check(1, "slow_gap2", h2 - h1, FB * BP1 + 1);
      end
    join

    // drain
    begin
      int t;
      t = 0;
      while ((qsize(0) != 0 || qsize(1) != 0 || busy_s[0] !== 1'b0 || busy_s[1] !== 1'b0)
             && t < 2 * FB * BP1) begin
        @(negedge clk);
        t++;
      end
      if (t >= 2 * FB * BP1) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout: frames still pending after %0d cycles", t);
      end
    end
    repeat (2) @(negedge clk);
    check(0, "queue_empty", qsize(0), 0);
    check(1, "queue_empty", qsize(1), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
